pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have port clock, in, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, in, 1, synchronous, active-high.
REQ-003 SHALL have port id_inst, in, 32, instruction currently in the ID stage.
REQ-004 SHALL have port id_valid, in, 1, id_inst holds a real instruction (0 = bubble).
REQ-005 SHALL have port branch_taken, in, 1, BEQ in MEM resolved taken (from EX/MEM).
REQ-006 SHALL have port dmem_ack, in, 1, data memory completes current access.
REQ-007 SHALL have port halt_req, in, 1, debug request to stop the pipeline.
REQ-008 SHALL have port pc_write, out, 1, PC register load enable.
REQ-009 SHALL have port ifid_write, out, 1, IF/ID register load enable.
REQ-010 SHALL have ports ifid_flush, idex_flush and exmem_flush, out, 1 each, load a bubble into that pipeline register.
REQ-011 SHALL have port pipe_freeze, out, 1, hold ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have port dmem_req, out, 1, data memory access request for the MEM-stage instruction.
REQ-013 SHALL have ports halted, out, 1, and stall_count, out, 16, saturating count of stall cycles.

Function
REQ-014 SHALL decode opcode [31:26]: SPECIAL 000000, ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100; any other opcode is a no-op (no dest, no mem, no sources).
REQ-015 SHALL derive dest register: SPECIAL uses rd [15:11]; ADDI/ANDI/ORI/LW use rt [20:16]; SW/BEQ have none; dest 0 is treated as none.
REQ-016 SHALL derive sources: rs [25:21] for all decoded ops; rt [20:16] additionally for SPECIAL, SW and BEQ.
REQ-017 SHALL keep a shadow pipeline of two slots, EX and MEM, each holding {valid, is_load, is_store, dest[4:0]}, advancing with the real pipeline registers.
REQ-018 SHALL keep an FSM with states RUN, MEM_WAIT and HALTED.
REQ-019 RUN: dmem_req = MEM slot valid and (is_load or is_store), combinational; if dmem_req and not dmem_ack, next state SHALL be MEM_WAIT and the current cycle SHALL be a freeze cycle.
REQ-020 MEM_WAIT: pipe_freeze=1, pc_write=0, ifid_write=0, dmem_req=1; on dmem_ack the state SHALL return to RUN and the pipeline SHALL advance in that same cycle.
REQ-021 Priority within a non-freeze cycle: branch_taken first, then load-use stall, then normal advance.
REQ-022 SHALL flush on branch_taken in RUN: ifid_flush, idex_flush and exmem_flush =1, pc_write=1, and shadow EX and MEM slots invalidated on the edge; a load-use stall in the same cycle SHALL be ignored.
REQ-023 SHALL stall on load-use when id_valid, EX slot is_load, and EX dest equals any ID source: pc_write=0, ifid_write=0, idex_flush=1, shadow EX slot loaded invalid; latency exactly one bubble.
REQ-024 Normal advance: pc_write=ifid_write=1, all flushes 0, EX slot <= decoded id_inst (valid=id_valid), MEM slot <= EX slot.
REQ-025 SHALL handle halt_req sampled in RUN when no freeze and no branch_taken: enter HALTED after that cycle advances; while HALTED, pc_write=ifid_write=0, pipe_freeze=1, halted=1; leave to RUN on the first cycle halt_req=0.
REQ-026 SHALL defer halt_req asserted during MEM_WAIT until return to RUN.
REQ-027 SHALL increment stall_count by one in every cycle with pc_write=0 while not HALTED; it SHALL saturate at 16'hFFFF.

Reset
REQ-028 SHALL, while reset=1 on an edge, set state RUN, both shadow slots invalid, stall_count 0.
REQ-029 Output values after reset SHALL be pc_write=1, ifid_write=1, all flushes 0, pipe_freeze=0, dmem_req=0, halted=0.
REQ-030 Reset mid-MEM_WAIT or HALTED SHALL abandon the access; dmem_req SHALL be 0 the cycle after.

Structure
REQ-031 Opcode, func and state encodings SHALL live in the shared decode include alongside existing OP_ constants.
REQ-032 SHALL be split into one sub-module, inst_classify (combinational: valid, is_load, is_store, dest, rs_used, rt_used), instantiated for the ID instruction.

Verification
REQ-033 SHALL cover load-use: LW $2 then ADD $3,$2,$4 -> one cycle pc_write=0, idex_flush=1, stall_count=1.
REQ-034 SHALL cover no false stall: LW $0 then ADD $3,$0,$0 -> no stall; LW $2 then SW $5,0($2) -> stall (rs match).
REQ-035 SHALL cover mem wait: LW reaches MEM, dmem_ack low 3 cycles -> pipe_freeze=1 for 3 cycles, advance on 4th, stall_count=4.
REQ-036 SHALL cover branch and load-use: branch_taken coincident with load-use -> all three flushes, pc_write=1, no stall counted.
REQ-037 SHALL cover halt: halt_req during MEM_WAIT -> HALTED only after ack; halt_req=0 -> RUN next cycle.
REQ-038 SHALL cover counter saturation and reset: force 70000 stall cycles -> stall_count=16'hFFFF; reset in MEM_WAIT -> dmem_req=0 next cycle.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared decode constants, FSM encoding and shadow-slot type for the pipeline
// hazard/stall controller.
package pipeline_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  // Shadow copy of what the EX / MEM pipeline registers currently hold.
  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       is_store;
    logic [4:0] dest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic logic [4:0] field_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] field_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

endpackage

// File: rtl/pipeline_control_inst_classify.sv
// Combinational classifier: memory kind, destination and which source
// fields an instruction actually reads.
module inst_classify
  import pipeline_control_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        valid,
  output logic        is_load,
  output logic        is_store,
  output logic [4:0]  dest,
  output logic        rs_used,
  output logic        rt_used
);

  logic [5:0] opcode;
  logic       unused_bits;

  assign opcode      = inst[31:26];
  assign valid       = inst_valid;
  assign unused_bits = ^inst[10:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    dest     = 5'd0;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        dest    = inst[15:11];
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dest    = inst[20:16];
        rs_used = 1'b1;
      end
      OP_LW: begin
        dest    = inst[20:16];
        rs_used = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        rs_used  = 1'b1;
        rt_used  = 1'b1;
        is_store = 1'b1;
      end
      OP_BEQ: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      default: ;
    endcase
    // A bubble must never look like a producer or consumer.
    if (!inst_valid) begin
      is_load  = 1'b0;
      is_store = 1'b0;
      dest     = 5'd0;
      rs_used  = 1'b0;
      rt_used  = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezes, debug halt and a saturating stall-cycle counter.
module pipeline_control
  import pipeline_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        branch_taken,
  input  logic        dmem_ack,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pipe_freeze,
  output logic        dmem_req,
  output logic        halted,
  output logic [15:0] stall_count
);

  state_t      state_reg, state_next;
  slot_t       ex_reg, ex_next;
  slot_t       mem_reg, mem_next;
  logic [15:0] stall_count_reg;

  logic       cls_valid, cls_is_load, cls_is_store, cls_rs_used, cls_rt_used;
  logic [4:0] cls_dest;
  logic [4:0] id_rs, id_rt;
  slot_t      id_slot;
  logic       mem_access;
  logic       load_use;
  logic       count_stall;

  inst_classify u_classify (
    .inst       (id_inst),
    .inst_valid (id_valid),
    .valid      (cls_valid),
    .is_load    (cls_is_load),
    .is_store   (cls_is_store),
    .dest       (cls_dest),
    .rs_used    (cls_rs_used),
    .rt_used    (cls_rt_used)
  );

  assign id_rs   = field_rs(id_inst);
  assign id_rt   = field_rt(id_inst);
  assign id_slot = {cls_valid, cls_is_load, cls_is_store, cls_dest};

  assign mem_access = mem_reg.valid & (mem_reg.is_load | mem_reg.is_store);

  // Register 0 is never a real producer, so a load to $0 cannot cause a stall.
  assign load_use = id_valid & ex_reg.valid & ex_reg.is_load & (ex_reg.dest != 5'd0) &
                    ((cls_rs_used & (id_rs == ex_reg.dest)) |
                     (cls_rt_used & (id_rt == ex_reg.dest)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    dmem_req    = 1'b0;
    state_next  = state_reg;
    ex_next     = ex_reg;
    mem_next    = mem_reg;

    case (state_reg)
      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
        if (!halt_req) state_next = ST_RUN;
      end
      default: begin
        dmem_req = mem_access | (state_reg == ST_MEM_WAIT);
        if (dmem_req && !dmem_ack) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_freeze = 1'b1;
          state_next  = ST_MEM_WAIT;
        end else begin
          // The ack cycle of a wait behaves as an ordinary advancing cycle.
          state_next = ST_RUN;
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            ex_next     = SLOT_EMPTY;
            mem_next    = SLOT_EMPTY;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            ex_next    = SLOT_EMPTY;
            mem_next   = ex_reg;
          end else begin
            ex_next  = id_slot;
            mem_next = ex_reg;
          end
          // A halt request raised during a wait only takes effect once back in RUN.
          if ((state_reg == ST_RUN) && halt_req && !branch_taken) begin
            state_next = ST_HALTED;
          end
        end
      end
    endcase
  end

  assign count_stall = !pc_write && (state_reg != ST_HALTED);
  assign halted      = (state_reg == ST_HALTED);
  assign stall_count = stall_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      ex_reg          <= SLOT_EMPTY;
      mem_reg         <= SLOT_EMPTY;
      stall_count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      ex_reg    <= ex_next;
      mem_reg   <= mem_next;
      if (count_stall && (stall_count_reg != STALL_MAX)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Table-driven, scoreboarded bench for pipeline_control: one table row per
// clock cycle, plus hand sequences for counter saturation and mid-wait reset.
module tb_pipeline_control;
  import pipeline_control_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        id_valid, branch_taken, dmem_ack, halt_req;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic        pipe_freeze, dmem_req, halted;
  logic [15:0] stall_count;

  pipeline_control dut (
    .clock        (clock),
    .reset        (reset),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .branch_taken (branch_taken),
    .dmem_ack     (dmem_ack),
    .halt_req     (halt_req),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_freeze  (pipe_freeze),
    .dmem_req     (dmem_req),
    .halted       (halted),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, dmem_req, halted}
  localparam logic [7:0] NORM  = 8'b1100_0000;
  localparam logic [7:0] NORMD = 8'b1100_0010;
  localparam logic [7:0] LU    = 8'b0001_0000;
  localparam logic [7:0] FLUSH = 8'b1111_1000;
  localparam logic [7:0] FRZ   = 8'b0000_0110;
  localparam logic [7:0] HALTO = 8'b0000_0101;

  typedef struct {
    logic [31:0] inst;
    logic        vld, br, ack, halt;
    logic [7:0]  exp_out;
    logic [15:0] exp_stall;
  } vec_t;

  typedef struct {
    int          id;
    logic [7:0]  out;
    logic [15:0] stall;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
                 pipe_freeze, dmem_req, halted};

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {OP_SPECIAL, rs, rt, rd, 5'd0, FUNC_ADD};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add(input logic [31:0] inst, input logic vld, input logic br,
                     input logic ack, input logic halt, input logic [7:0] eo,
                     input logic [15:0] es);
    vec_t v;
    v.inst = inst; v.vld = vld; v.br = br; v.ack = ack; v.halt = halt;
    v.exp_out = eo; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  // Drive one cycle just after the rising edge, score it mid-cycle.
  task automatic step(input int id, input vec_t v);
    exp_t e, got;
    id_inst      = v.inst;
    id_valid     = v.vld;
    branch_taken = v.br;
    dmem_ack     = v.ack;
    halt_req     = v.halt;
    e.id = id; e.out = v.exp_out; e.stall = v.exp_stall;
    sb.push_back(e);
    #4;
    got = sb.pop_front();
    n_cmp++;
    if (outs !== got.out) begin
      n_err++;
      $display("FAIL v%0d outputs: got %b want %b", got.id, outs, got.out);
    end
    n_cmp++;
    if (stall_count !== got.stall) begin
      n_err++;
      $display("FAIL v%0d stall_count: got %0d want %0d", got.id, stall_count, got.stall);
    end
    $display("v%0d inst=%h vld=%b br=%b ack=%b halt=%b outs=%b stall=%0d",
             got.id, v.inst, v.vld, v.br, v.ack, v.halt, outs, stall_count);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] lw2, lw0, add_dep, add_rt, add_zero, sw_dep, ori_nodep, unk, bub;
    vec_t v;
    lw2       = i_type(OP_LW, 5'd1, 5'd2, 16'd0);
    lw0       = i_type(OP_LW, 5'd1, 5'd0, 16'd0);
    add_dep   = r_type(5'd2, 5'd4, 5'd3);
    add_rt    = r_type(5'd4, 5'd2, 5'd3);
    add_zero  = r_type(5'd0, 5'd0, 5'd3);
    sw_dep    = i_type(OP_SW, 5'd2, 5'd5, 16'd0);
    ori_nodep = i_type(OP_ORI, 5'd7, 5'd2, 16'd5);
    unk       = i_type(6'h3F, 5'd2, 5'd2, 16'd0);
    bub       = 32'd0;

    // reset state
    add(bub, 0, 0, 1, 0, NORM, 0);
    // load-use: LW $2 ; ADD $3,$2,$4
    add(lw2, 1, 0, 1, 0, NORM, 0);
    add(add_dep, 1, 0, 1, 0, LU, 0);
    add(add_dep, 1, 0, 1, 0, NORMD, 1);
    add(bub, 0, 0, 1, 0, NORM, 1);
    add(bub, 0, 0, 1, 0, NORM, 1);
    // LW $0 ; ADD $3,$0,$0 -> no stall ; LW $2 ; SW $5,0($2) -> stall
    add(lw0, 1, 0, 1, 0, NORM, 1);
    add(add_zero, 1, 0, 1, 0, NORM, 1);
    add(lw2, 1, 0, 1, 0, NORMD, 1);
    add(sw_dep, 1, 0, 1, 0, LU, 1);
    add(sw_dep, 1, 0, 1, 0, NORMD, 2);
    add(bub, 0, 0, 1, 0, NORM, 2);
    add(bub, 0, 0, 1, 0, NORMD, 2);
    // LW $2 ; ORI $2,$7,5 -> rt is a destination, not a source
    add(lw2, 1, 0, 1, 0, NORM, 2);
    add(ori_nodep, 1, 0, 1, 0, NORM, 2);
    add(bub, 0, 0, 1, 0, NORMD, 2);
    add(bub, 0, 0, 1, 0, NORM, 2);
    // branch taken coincident with load-use
    add(lw2, 1, 0, 1, 0, NORM, 2);
    add(add_dep, 1, 1, 1, 0, FLUSH, 2);
    add(bub, 0, 0, 1, 0, NORM, 2);
    // load-use then three cycles without ack
    add(lw2, 1, 0, 1, 0, NORM, 2);
    add(add_dep, 1, 0, 1, 0, LU, 2);
    add(add_dep, 1, 0, 0, 0, FRZ, 3);
    add(add_dep, 1, 0, 0, 0, FRZ, 4);
    add(add_dep, 1, 0, 0, 0, FRZ, 5);
    add(add_dep, 1, 0, 1, 0, NORMD, 6);
    add(bub, 0, 0, 1, 0, NORM, 6);
    add(bub, 0, 0, 1, 0, NORM, 6);
    // halt requested during a memory wait
    add(lw2, 1, 0, 1, 0, NORM, 6);
    add(bub, 0, 0, 1, 0, NORM, 6);
    add(bub, 0, 0, 0, 1, FRZ, 6);
    add(bub, 0, 0, 0, 1, FRZ, 7);
    add(bub, 0, 0, 1, 1, NORMD, 8);
    add(bub, 0, 0, 1, 1, NORM, 8);
    add(bub, 0, 0, 1, 1, HALTO, 8);
    add(bub, 0, 0, 1, 0, HALTO, 8);
    add(bub, 0, 0, 1, 0, NORM, 8);
    // rt dependency on a SPECIAL
    add(lw2, 1, 0, 1, 0, NORM, 8);
    add(add_rt, 1, 0, 1, 0, LU, 8);
    add(add_rt, 1, 0, 1, 0, NORMD, 9);
    add(bub, 0, 0, 1, 0, NORM, 9);
    add(bub, 0, 0, 1, 0, NORM, 9);
    // unknown opcode and invalid ID never stall
    add(lw2, 1, 0, 1, 0, NORM, 9);
    add(unk, 1, 0, 1, 0, NORM, 9);
    add(bub, 0, 0, 1, 0, NORMD, 9);
    add(lw2, 1, 0, 1, 0, NORM, 9);
    add(add_dep, 0, 0, 1, 0, NORM, 9);
    add(bub, 0, 0, 1, 0, NORMD, 9);
    add(bub, 0, 0, 1, 0, NORM, 9);
    // lead-in for the saturation run: LW parked in MEM
    add(lw2, 1, 0, 1, 0, NORM, 9);
    add(bub, 0, 0, 1, 0, NORM, 9);

    reset = 1'b1; id_inst = '0; id_valid = 1'b0;
    branch_taken = 1'b0; dmem_ack = 1'b1; halt_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // hold the memory wait far past the counter range
    id_inst = bub; id_valid = 1'b0; dmem_ack = 1'b0;
    repeat (70000) @(posedge clock);
    #1;
    v.inst = bub; v.vld = 0; v.br = 0; v.ack = 0; v.halt = 0;
    v.exp_out = FRZ; v.exp_stall = 16'hFFFF;
    step(1000, v);

    // reset while still waiting abandons the access
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    v.exp_out = NORM; v.exp_stall = 16'd0;
    step(1001, v);
    v.ack = 1; v.inst = lw2; v.vld = 1;
    step(1002, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
